// File: rtl/spi_peripheral_sp3.sv
// SPI peripheral with a word-addressed register file.
// Frame: WnR bit, 10 address bits (LSB first), then data bits LSB first.
// Writes commit per word with auto-increment; a short final word is merged
// into the existing contents. Reads stream word bits out on poci.
module spi_peripheral_sp3 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_WORDS          = 16
) (
    input  logic                          spi_clk,
    input  logic                          reset,
    input  logic                          cs_b,
    input  logic                          pico,
    output logic                          poci,
    input  logic [$clog2(NUM_WORDS)-1:0]  reg_rd_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg_rd_data,
    output logic                          wr_strobe,
    output logic [9:0]                    wr_index,
    output logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
    output logic                          busy
);

    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int AW = $clog2(NUM_WORDS);
    localparam int BW = $clog2(W);
    // Counter also walks the 10 address bits, so it needs at least 4 bits.
    localparam int CW = (BW < 4) ? 4 : BW;
    localparam logic [10:0] NW11 = 11'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, GET_ADDR, WRITE, READ} state_t;

    state_t          state;
    logic            wnr;
    logic [9:0]      addr;
    logic [9:0]      offset;
    logic [CW-1:0]   bitcnt;
    logic [W-1:0]    data;
    logic [W-1:0]    mem [NUM_WORDS];

    logic [9:0]      cur_idx;
    logic            in_range;
    logic [BW-1:0]   bidx;
    logic [W-1:0]    cur_word;
    logic [W-1:0]    shifted;
    logic [W-1:0]    mask;
    logic [W-1:0]    partial;
    logic            commit_en;
    logic [W-1:0]    commit_val;

    assign cur_idx     = addr + offset;
    assign in_range    = ({1'b0, cur_idx} < NW11);
    assign bidx        = bitcnt[BW-1:0];
    assign reg_rd_data = mem[reg_rd_addr];
    assign busy        = (state != IDLE);

    // Word assembly, partial-word merge, commit decision and read bit select.
    always_comb begin
        cur_word      = in_range ? mem[cur_idx[AW-1:0]] : '0;
        shifted       = data;
        shifted[bidx] = pico;
        mask          = (W'(1) << bidx) - W'(1);
        partial       = (data & mask) | (cur_word & ~mask);
        if (cs_b) begin
            commit_en  = (state == WRITE) && (bitcnt != '0);
            commit_val = partial;
        end else begin
            commit_en  = (state == WRITE) && (bitcnt == CW'(W - 1));
            commit_val = shifted;
        end
        poci = ((state == READ) && in_range) ? cur_word[bidx] : 1'b0;
    end

    // Transaction FSM, counters and registered commit notification.
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wnr       <= 1'b0;
            addr      <= '0;
            offset    <= '0;
            bitcnt    <= '0;
            data      <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= commit_en;
            if (commit_en) begin
                wr_index <= cur_idx;
                wr_data  <= commit_val;
            end
            if (cs_b) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        wnr    <= pico;
                        addr   <= '0;
                        offset <= '0;
                        bitcnt <= '0;
                        state  <= GET_ADDR;
                    end
                    GET_ADDR: begin
                        addr[bitcnt[3:0]] <= pico;
                        if (bitcnt == CW'(9)) begin
                            bitcnt <= '0;
                            offset <= '0;
                            state  <= wnr ? WRITE : READ;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        data[bidx] <= pico;
                        if (bitcnt == CW'(W - 1)) begin
                            bitcnt <= '0;
                            offset <= offset + 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    READ: begin
                        if (bitcnt == CW'(W - 1)) begin
                            bitcnt <= '0;
                            offset <= offset + 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Register file: cleared on reset, written only by in-range commits.
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else if (commit_en && in_range) begin
            mem[cur_idx[AW-1:0]] <= commit_val;
        end
    end

endmodule

// File: tb/tb_spi_peripheral_sp3.sv
// Bench for spi_peripheral_sp3: directed frame table, hand-written corner
// sequences (abort, reset mid-frame) and random frames against a word-level model.
module tb_spi_peripheral_sp3;

    logic        spi_clk;
    logic        reset;
    logic        cs_b;
    logic        pico;
    logic        poci;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        wr_strobe;
    logic [9:0]  wr_index;
    logic [31:0] wr_data;
    logic        busy;

    spi_peripheral_sp3 #(.C_S_AXI_DATA_WIDTH(32), .NUM_WORDS(16)) dut (
        .spi_clk    (spi_clk),
        .reset      (reset),
        .cs_b       (cs_b),
        .pico       (pico),
        .poci       (poci),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    typedef struct {
        logic [9:0]  idx;
        logic [31:0] val;
    } commit_t;

    typedef struct {
        logic        wnr;
        logic [9:0]  addr;
        int          nbits;
        logic [63:0] data;
        logic [3:0]  chk_idx;
        logic [31:0] exp_word;
        int          exp_strobes;
    } vec_t;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [16];
    commit_t     exp_q [$];
    commit_t     got_q [$];
    vec_t        tbl [8];

    // Capture every strobe pulse just after the edge that produced it.
    always @(posedge spi_clk) begin
        #1;
        if (wr_strobe === 1'b1) begin
            commit_t c;
            c.idx = wr_index;
            c.val = wr_data;
            got_q.push_back(c);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Word-level model of a write frame: split the bit stream into words,
    // the last short word keeps the untouched high bits of the old value.
    task automatic model_write(input logic [9:0] addr, input int nbits, input logic [63:0] data);
        int k = 0;
        int rem = nbits;
        while (rem > 0) begin
            int          n   = (rem >= 32) ? 32 : rem;
            int          idx = (int'(addr) + k) % 1024;
            logic [31:0] old = (idx < 16) ? ref_mem[idx] : 32'h0;
            logic [31:0] nv  = old;
            commit_t     c;
            for (int b = 0; b < n; b++) nv[b] = data[(k * 32 + b) % 64];
            c.idx = 10'(idx);
            c.val = nv;
            exp_q.push_back(c);
            if (idx < 16) ref_mem[idx] = nv;
            rem -= n;
            k++;
        end
    endtask

    function automatic logic model_read_bit(input logic [9:0] addr, input int i);
        int idx = (int'(addr) + i / 32) % 1024;
        logic [31:0] w;
        if (idx >= 16) return 1'b0;
        w = ref_mem[idx];
        return w[i % 32];
    endfunction

    task automatic compare_commits(input string tag);
        check({tag, "_strobe_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_wr_index"}, 64'(got_q[i].idx), 64'(exp_q[i].idx));
            check({tag, "_wr_data"}, 64'(got_q[i].val), 64'(exp_q[i].val));
        end
    endtask

    // Full frame: select edge, 10 address bits, nbits data, then cs_b high.
    task automatic frame(input logic wnr, input logic [9:0] addr, input int nbits,
                         input logic [63:0] data, input string tag);
        exp_q.delete();
        got_q.delete();
        @(negedge spi_clk);
        cs_b = 1'b0;
        pico = wnr;
        @(posedge spi_clk);
        #1 check({tag, "_busy_start"}, 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge spi_clk);
            pico = addr[i];
            @(posedge spi_clk);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge spi_clk);
            if (wnr) pico = data[i % 64];
            else check({tag, "_poci"}, 64'(poci), 64'(model_read_bit(addr, i)));
            @(posedge spi_clk);
        end
        @(negedge spi_clk);
        cs_b = 1'b1;
        pico = 1'b0;
        @(posedge spi_clk);
        #1;
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_poci_idle"}, 64'(poci), 64'd0);
        if (wnr) model_write(addr, nbits, data);
        @(negedge spi_clk);
        compare_commits(tag);
    endtask

    initial begin
        reset       = 1'b1;
        cs_b        = 1'b1;
        pico        = 1'b0;
        reg_rd_addr = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        tbl[0] = '{1'b1, 10'd3,    32, 64'h0000_0000_A5A5_0F0F, 4'd3,  32'hA5A5_0F0F, 1};
        tbl[1] = '{1'b0, 10'd3,    32, 64'h0,                   4'd3,  32'hA5A5_0F0F, 0};
        tbl[2] = '{1'b1, 10'd5,    32, 64'h0000_0000_FFFF_FFFF, 4'd5,  32'hFFFF_FFFF, 1};
        tbl[3] = '{1'b1, 10'd5,     8, 64'h0,                   4'd5,  32'hFFFF_FF00, 1};
        tbl[4] = '{1'b1, 10'd15,   64, 64'h1111_1111_2222_2222, 4'd15, 32'h2222_2222, 2};
        tbl[5] = '{1'b0, 10'd20,   32, 64'h0,                   4'd15, 32'h2222_2222, 0};
        tbl[6] = '{1'b1, 10'd1023, 40, 64'h0000_00AB_DEAD_BEEF, 4'd0,  32'h0000_00AB, 2};
        tbl[7] = '{1'b1, 10'd3,     0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3,  32'hA5A5_0F0F, 0};

        // Reset state
        repeat (3) @(posedge spi_clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_poci", 64'(poci), 64'd0);
        check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        check("rst_wr_index", 64'(wr_index), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_regfile", 64'(reg_rd_data), 64'd0);
        @(negedge spi_clk);
        reset = 1'b0;

        // Directed frame table
        for (int v = 0; v < 8; v++) begin
            frame(tbl[v].wnr, tbl[v].addr, tbl[v].nbits, tbl[v].data, $sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_strobes", v), 64'(got_q.size()), 64'(tbl[v].exp_strobes));
            reg_rd_addr = tbl[v].chk_idx;
            #1 check($sformatf("tbl%0d_word", v), 64'(reg_rd_data), 64'(tbl[v].exp_word));
        end
        for (int i = 0; i < 16; i++) begin
            reg_rd_addr = 4'(i);
            #1 check($sformatf("regfile_after_tbl_w%0d", i), 64'(reg_rd_data), 64'(ref_mem[i]));
        end

        // Abort during address phase, then an immediate write
        got_q.delete();
        @(negedge spi_clk);
        cs_b = 1'b0;
        pico = 1'b1;
        @(posedge spi_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge spi_clk);
            pico = 1'b1;
            @(posedge spi_clk);
        end
        @(negedge spi_clk);
        cs_b = 1'b1;
        @(posedge spi_clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_strobe", 64'(got_q.size()), 64'd0);
        frame(1'b1, 10'd1, 32, 64'h1234_5678, "after_abort");
        reg_rd_addr = 4'd1;
        #1 check("after_abort_word1", 64'(reg_rd_data), 64'h1234_5678);

        // Reset in the middle of write data
        got_q.delete();
        @(negedge spi_clk);
        cs_b = 1'b0;
        pico = 1'b1;
        @(posedge spi_clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge spi_clk);
            pico = (i < 3) ? 1'b1 : 1'b0;
            @(posedge spi_clk);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge spi_clk);
            pico = ~pico;
            @(posedge spi_clk);
        end
        @(negedge spi_clk);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_poci", 64'(poci), 64'd0);
        check("midrst_wr_strobe", 64'(wr_strobe), 64'd0);
        check("midrst_wr_index", 64'(wr_index), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        reg_rd_addr = 4'd7;
        #1 check("midrst_target_word", 64'(reg_rd_data), 64'd0);
        reg_rd_addr = 4'd3;
        #1 check("midrst_word3_cleared", 64'(reg_rd_data), 64'd0);
        @(posedge spi_clk);
        @(negedge spi_clk);
        cs_b  = 1'b1;
        reset = 1'b0;
        @(posedge spi_clk);
        #1 check("midrst_no_strobe", 64'(got_q.size()), 64'd0);
        frame(1'b1, 10'd7, 32, 64'hCAFE_F00D, "after_rst");
        frame(1'b0, 10'd7, 32, 64'h0, "after_rst_rd");

        // Random frames against the model
        for (int n = 0; n < 40; n++) begin
            logic        wnr   = 1'($urandom_range(0, 1));
            logic [9:0]  addr  = 10'($urandom_range(0, 19));
            int          nbits = $urandom_range(0, 64);
            logic [63:0] data  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) addr = 10'(1020 + $urandom_range(0, 3));
            frame(wnr, addr, nbits, data, $sformatf("rnd%0d", n));
        end
        for (int i = 0; i < 16; i++) begin
            reg_rd_addr = 4'(i);
            #1 check($sformatf("regfile_final_w%0d", i), 64'(reg_rd_data), 64'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
